// File: rtl/instr_sequencer_if.sv
// Bus bundle between the 6502 bus interface / interrupt logic and the instruction sequencer.
// The master drives the sequencing controls; the slave returns IR, cycle and status.
interface instr_sequencer_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CYC_W  = 3
);
    logic              rdy;
    logic [DATA_W-1:0] data;
    logic              inc_cycle;
    logic              res_cycle;
    logic              nmi_n;
    logic              irq_n;
    logic              irq_mask;
    logic [DATA_W-1:0] IR;
    logic [CYC_W-1:0]  cycle;
    logic              sync;
    logic [1:0]        int_src;
    logic              cycle_ovf;

    modport master (
        output rdy, data, inc_cycle, res_cycle, nmi_n, irq_n, irq_mask,
        input  IR, cycle, sync, int_src, cycle_ovf
    );

    modport slave (
        input  rdy, data, inc_cycle, res_cycle, nmi_n, irq_n, irq_mask,
        output IR, cycle, sync, int_src, cycle_ovf
    );
endinterface

// File: rtl/instr_sequencer.sv
// Instruction register and per-instruction cycle sequencer with rdy stall, NMI/IRQ BRK injection
// and sticky cycle overflow. Optional INSTR_COUNT_EN macro adds a 32-bit fetch counter (instr_cnt).
module instr_sequencer #(
    parameter int unsigned       DATA_W     = 8,
    parameter int unsigned       CYC_W      = 3,
    parameter logic [DATA_W-1:0] BRK_OPCODE = '0
) (
    input  logic                clk_ph1,
    input  logic                rst,
`ifdef INSTR_COUNT_EN
    output logic [31:0]         instr_cnt,
`endif
    instr_sequencer_if.slave    bus
);
    localparam logic [CYC_W-1:0] CYC_MAX = {CYC_W{1'b1}};

    localparam logic [1:0] SRC_FETCH = 2'd0;
    localparam logic [1:0] SRC_IRQ   = 2'd1;
    localparam logic [1:0] SRC_NMI   = 2'd2;
    localparam logic [1:0] SRC_RESET = 2'd3;

    logic [DATA_W-1:0] ir_q,      ir_d;
    logic [CYC_W-1:0]  cycle_q,   cycle_d;
    logic [1:0]        src_q,     src_d;
    logic              ovf_q,     ovf_d;
    logic              nmi_pend_q, nmi_pend_d;
    logic              nmi_hist_q;
    logic              nmi_fall;
    logic              fetch;

    // State registers; reset wins over rdy and all other inputs
    always_ff @(posedge clk_ph1) begin
        if (!rst) begin
            ir_q       <= BRK_OPCODE;
            cycle_q    <= '0;
            src_q      <= SRC_RESET;
            ovf_q      <= 1'b0;
            nmi_pend_q <= 1'b0;
            nmi_hist_q <= 1'b1;
        end else begin
            ir_q       <= ir_d;
            cycle_q    <= cycle_d;
            src_q      <= src_d;
            ovf_q      <= ovf_d;
            nmi_pend_q <= nmi_pend_d;
            nmi_hist_q <= bus.nmi_n;
        end
    end

    // Falling-edge detect runs regardless of rdy
    assign nmi_fall = nmi_hist_q & ~bus.nmi_n;

    // Next-state: res_cycle beats inc_cycle; fetch picks NMI, then unmasked IRQ, then bus data
    always_comb begin
        ir_d       = ir_q;
        cycle_d    = cycle_q;
        src_d      = src_q;
        ovf_d      = ovf_q;
        nmi_pend_d = nmi_pend_q | nmi_fall;
        fetch      = 1'b0;

        if (bus.rdy) begin
            if (bus.res_cycle) begin
                cycle_d = '0;
                ovf_d   = 1'b0;
            end else if (bus.inc_cycle) begin
                if (cycle_q == '0) begin
                    fetch   = 1'b1;
                    cycle_d = CYC_W'(1);
                    if (nmi_pend_q) begin
                        // An edge arriving while already pending is absorbed by this injection
                        ir_d       = BRK_OPCODE;
                        src_d      = SRC_NMI;
                        nmi_pend_d = 1'b0;
                    end else if (!bus.irq_n && !bus.irq_mask) begin
                        ir_d  = BRK_OPCODE;
                        src_d = SRC_IRQ;
                    end else begin
                        ir_d  = bus.data;
                        src_d = SRC_FETCH;
                    end
                end else if (cycle_q != CYC_MAX) begin
                    cycle_d = cycle_q + CYC_W'(1);
                end else begin
                    ovf_d = 1'b1;
                end
            end
        end
    end

`ifdef INSTR_COUNT_EN
    logic [31:0] cnt_q;

    always_ff @(posedge clk_ph1) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (fetch) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    assign instr_cnt = cnt_q;
`else
    logic unused_fetch;
    assign unused_fetch = fetch;
`endif

    assign bus.IR        = ir_q;
    assign bus.cycle     = cycle_q;
    assign bus.int_src   = src_q;
    assign bus.cycle_ovf = ovf_q;
    assign bus.sync      = (cycle_q == '0);

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: a behavioural model checked every cycle plus literal
// expectations at the key points of each scenario.
`timescale 1ns/1ps
module tb_instr_sequencer;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned CYC_W  = 3;
    localparam logic [7:0]  BRK    = 8'h00;
    localparam int          MAXC   = (1 << CYC_W) - 1;

    logic clk_ph1 = 1'b0;
    logic rst;
    int   passed = 0;
    int   total  = 0;

    instr_sequencer_if #(.DATA_W(DATA_W), .CYC_W(CYC_W)) bus ();

`ifdef INSTR_COUNT_EN
    logic [31:0] instr_cnt;
    instr_sequencer #(.DATA_W(DATA_W), .CYC_W(CYC_W), .BRK_OPCODE(BRK)) dut (
        .clk_ph1(clk_ph1), .rst(rst), .instr_cnt(instr_cnt), .bus(bus));
`else
    instr_sequencer #(.DATA_W(DATA_W), .CYC_W(CYC_W), .BRK_OPCODE(BRK)) dut (
        .clk_ph1(clk_ph1), .rst(rst), .bus(bus));
`endif

    always #5 clk_ph1 = ~clk_ph1;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    // Behavioural model: plain integers, updated from the inputs seen at each rising edge
    int   m_ir, m_cyc, m_src, m_ovf, m_pend, m_prev, m_valid;
    longint m_cnt;

    always @(posedge clk_ph1) begin
        if (!rst) begin
            m_ir = BRK; m_cyc = 0; m_src = 3; m_ovf = 0; m_pend = 0; m_prev = 1; m_cnt = 0;
            m_valid = 1;
        end else if (m_valid == 1) begin
            int fall;
            fall = (m_prev == 1 && bus.nmi_n == 1'b0) ? 1 : 0;
            if (bus.rdy) begin
                if (bus.res_cycle) begin
                    m_cyc = 0; m_ovf = 0;
                end else if (bus.inc_cycle) begin
                    if (m_cyc == 0) begin
                        m_cnt = (m_cnt + 1) % 64'h1_0000_0000;
                        if (m_pend == 1) begin
                            m_ir = BRK; m_src = 2; m_pend = 0; fall = 0;
                        end else if (!bus.irq_n && !bus.irq_mask) begin
                            m_ir = BRK; m_src = 1;
                        end else begin
                            m_ir = int'(bus.data); m_src = 0;
                        end
                        m_cyc = 1;
                    end else if (m_cyc == MAXC) begin
                        m_ovf = 1;
                    end else begin
                        m_cyc = m_cyc + 1;
                    end
                end
            end
            if (fall == 1) m_pend = 1;
            m_prev = int'(bus.nmi_n);
        end
        #2;
        if (m_valid == 1) begin
            check("IR",        longint'(bus.IR),        longint'(m_ir));
            check("cycle",     longint'(bus.cycle),     longint'(m_cyc));
            check("int_src",   longint'(bus.int_src),   longint'(m_src));
            check("cycle_ovf", longint'(bus.cycle_ovf), longint'(m_ovf));
            check("sync",      longint'(bus.sync),      (m_cyc == 0) ? 64'd1 : 64'd0);
`ifdef INSTR_COUNT_EN
            check("instr_cnt", longint'(instr_cnt),     m_cnt);
`endif
        end
    end

    // Advance n rising edges; inputs change and literals are sampled 3ns after the edge
    task automatic step(input int n);
        repeat (n) @(posedge clk_ph1);
        #3;
    endtask

    task automatic fetch_new(input logic [7:0] d);
        bus.inc_cycle = 1'b1; bus.res_cycle = 1'b1; step(1);
        bus.res_cycle = 1'b0; bus.data = d;         step(1);
    endtask

    initial begin
        m_valid = 0;
        rst = 1'b0;
        bus.rdy = 1'b1; bus.data = 8'h00; bus.inc_cycle = 1'b0; bus.res_cycle = 1'b0;
        bus.nmi_n = 1'b1; bus.irq_n = 1'b1; bus.irq_mask = 1'b1;
        step(2);
        check("rst_IR",    longint'(bus.IR),      64'h00);
        check("rst_src",   longint'(bus.int_src), 64'd3);
        check("rst_cycle", longint'(bus.cycle),   64'd0);
        check("rst_sync",  longint'(bus.sync),    64'd1);

        // Reset release with a fetch pending
        rst = 1'b1; bus.data = 8'h41; bus.inc_cycle = 1'b1;
        step(1);
        check("fetch_IR",    longint'(bus.IR),      64'h41);
        check("fetch_src",   longint'(bus.int_src), 64'd0);
        check("fetch_cycle", longint'(bus.cycle),   64'd1);
        step(6);
        check("cyc7",     longint'(bus.cycle),     64'd7);
        check("cyc7_ovf", longint'(bus.cycle_ovf), 64'd0);
        step(2);
        check("sat_cycle", longint'(bus.cycle),     64'd7);
        check("sat_ovf",   longint'(bus.cycle_ovf), 64'd1);

        // res_cycle beats inc_cycle
        fetch_new(8'h41); step(2);
        check("pre_res_cycle", longint'(bus.cycle), 64'd3);
        bus.res_cycle = 1'b1; bus.data = 8'h99; step(1);
        check("res_cycle", longint'(bus.cycle),     64'd0);
        check("res_ovf",   longint'(bus.cycle_ovf), 64'd0);
        check("res_IR",    longint'(bus.IR),        64'h41);

        // Stall at cycle 2
        bus.res_cycle = 1'b0; bus.data = 8'h41; step(2);
        bus.rdy = 1'b0; step(4);
        check("stall_cycle", longint'(bus.cycle), 64'd2);
        bus.rdy = 1'b1; step(1);
        check("unstall_cycle", longint'(bus.cycle), 64'd3);

        // NMI beats IRQ, then IRQ on the following fetch
        bus.irq_n = 1'b0; bus.irq_mask = 1'b0;
        bus.nmi_n = 1'b0; step(1); bus.nmi_n = 1'b1; step(1);
        fetch_new(8'hA9);
        check("nmi_IR",  longint'(bus.IR),      64'h00);
        check("nmi_src", longint'(bus.int_src), 64'd2);
        fetch_new(8'hA9);
        check("irq_IR",  longint'(bus.IR),      64'h00);
        check("irq_src", longint'(bus.int_src), 64'd1);

        // Masked IRQ fetches bus data
        bus.irq_mask = 1'b1;
        fetch_new(8'hEA);
        check("mask_IR",  longint'(bus.IR),      64'hEA);
        check("mask_src", longint'(bus.int_src), 64'd0);

        // NMI edge captured during stall
        bus.irq_n = 1'b1; step(1);
        bus.rdy = 1'b0; bus.nmi_n = 1'b0; step(1); bus.nmi_n = 1'b1; step(2);
        bus.rdy = 1'b1;
        fetch_new(8'h55);
        check("stall_nmi_src", longint'(bus.int_src), 64'd2);

        // Edge coincident with fetch is deferred one fetch
        bus.inc_cycle = 1'b1; bus.res_cycle = 1'b1; step(1);
        bus.res_cycle = 1'b0; bus.data = 8'h66; bus.nmi_n = 1'b0; step(1);
        bus.nmi_n = 1'b1;
        check("coinc_IR",  longint'(bus.IR),      64'h66);
        check("coinc_src", longint'(bus.int_src), 64'd0);
        fetch_new(8'h77);
        check("defer_src", longint'(bus.int_src), 64'd2);

        // Mid-instruction reset discards a pending NMI
        bus.nmi_n = 1'b0; step(1); bus.nmi_n = 1'b1;
        rst = 1'b0; step(1);
        check("mid_rst_src", longint'(bus.int_src), 64'd3);
        rst = 1'b1; bus.data = 8'h12; step(1);
        check("post_rst_IR",  longint'(bus.IR),      64'h12);
        check("post_rst_src", longint'(bus.int_src), 64'd0);
`ifdef INSTR_COUNT_EN
        check("cnt_after_rst", longint'(instr_cnt), 64'd1);
`endif
        step(2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
